multi_core_run_ctrl: RTL and testbench
======================================

MULTI_CORE_RUN_CTRL -- requirements
Module: multi_core_run_ctrl

Interface
- REQ-001 The block SHALL have parameter CORE_COUNT, default 4, number of processor cores controlled.
- REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, width of the run-cycle and timeout counters.
- REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum RUN cycles before abort; 0 disables the timeout.
- REQ-004 clk  input  1  single clock; all state changes on the rising edge.
- REQ-005 rstN  input  1  asynchronous, active-low reset.
- REQ-006 start  input  1  host run request; level-sampled.
- REQ-007 coreReady  input  CORE_COUNT  per-core ready; bit i belongs to core i.
- REQ-008 coreDone  input  CORE_COUNT  per-core done; pulse or level accepted.
- REQ-009 processStart  output  1  start pulse broadcast to all cores.
- REQ-010 busy  output  1  high in every state except IDLE and ERROR.
- REQ-011 allDone  output  1  one-cycle completion pulse.
- REQ-012 timeout  output  1  sticky abort flag.
- REQ-013 runCycles  output  CNT_WIDTH  cycles spent in RUN by the last run; present only per REQ-030.

Function
- REQ-014 The FSM SHALL have states IDLE, WAIT_READY, START, RUN, FINISH and ERROR.
- REQ-015 IDLE->WAIT_READY SHALL occur when start=1; start in any other state SHALL be ignored, except in ERROR (REQ-024).
- REQ-016 WAIT_READY->START SHALL occur in the first cycle in which all coreReady bits are 1; the timeout does not apply in WAIT_READY.
- REQ-017 processStart SHALL be 1 for exactly the one cycle spent in START; START->RUN is unconditional.
- REQ-018 A CORE_COUNT-bit done mask SHALL clear in START and, in RUN only, OR in coreDone each cycle; coreDone outside RUN SHALL be ignored.
- REQ-019 RUN->FINISH SHALL occur in the cycle in which the mask, including the current cycle's coreDone, is all ones. The minimum is one RUN cycle when all cores assert done in the first RUN cycle.
- REQ-020 allDone SHALL be 1 for exactly the one cycle spent in FINISH; FINISH->IDLE is unconditional.
- REQ-021 Latency from start sampled in IDLE (with all cores ready) to processStart SHALL be 2 cycles.
- REQ-022 A cycle counter SHALL clear in START, increment each RUN cycle, and saturate at all-ones.
- REQ-023 When TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 in a RUN cycle without completion, the FSM SHALL go to ERROR and set timeout=1. Completion in the same cycle SHALL win: go to FINISH, no timeout.
- REQ-024 ERROR SHALL hold timeout=1 and busy=0; start=1 in ERROR SHALL clear timeout and go to WAIT_READY.

Reset
- REQ-025 Asserting rstN=0 at any time, including mid-run, SHALL immediately force IDLE, clear the mask and counter, and drive processStart=0, busy=0, allDone=0, timeout=0, runCycles=0.
- REQ-026 After deassertion, the first state change SHALL occur on the first rising edge with rstN=1.

Configuration
- REQ-027 The block SHALL use macro RUN_CYCLE_COUNT_EN.
- REQ-028 With RUN_CYCLE_COUNT_EN defined, runCycles SHALL load the counter value plus one, saturating, on the RUN->FINISH or RUN->ERROR transition, and hold it until the next such transition or reset.
- REQ-029 Without RUN_CYCLE_COUNT_EN, the runCycles port and its register SHALL be absent; the internal counter remains for timeout.
- REQ-030 runCycles SHALL exist only when RUN_CYCLE_COUNT_EN is defined.

Structure
- REQ-031 The state enum type SHALL reside in shared package multi_core_pkg, alongside the existing core-count and width constants.
- REQ-032 The block SHALL be one module with no sub-modules; the done mask and counter are inline.

Verification
- REQ-033 CORE_COUNT=4, all ready, start=1 in IDLE -> processStart at cycle 2; cores done at RUN cycles 3,5,5,7 -> allDone pulses once in the cycle after the last done, runCycles=7.
- REQ-034 coreReady=4'b1011 for 10 cycles, then 4'b1111 -> processStart occurs exactly 1 cycle after full readiness; busy stays 1 throughout.
- REQ-035 TIMEOUT_CYCLES=20, core 2 never done -> ERROR after 20 RUN cycles with timeout=1 and busy=0; then start=1 -> timeout clears and a new run starts.
- REQ-036 coreDone=4'b1111 pulsed in IDLE and during START, then cores done normally -> the early pulses are ignored; completion follows only the RUN-time dones.
- REQ-037 rstN pulsed low in RUN cycle 4 -> all outputs are 0 asynchronously and the state is IDLE; start=1 while busy -> no second processStart.
- REQ-038 Build without RUN_CYCLE_COUNT_EN -> runCycles port absent; REQ-033 passes except the runCycles check.

Source files
------------

// File: rtl/multi_core_pkg.sv
// Shared constants and the run-state enum for the multi-core run controller.
// Optional runCycles port is enabled by defining RUN_CYCLE_COUNT_EN.
package multi_core_pkg;

    localparam int unsigned CORE_COUNT_DEFAULT = 4;
    localparam int unsigned CNT_WIDTH_DEFAULT  = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        START,
        RUN,
        FINISH,
        ERROR
    } run_state_t;

endpackage

// File: rtl/multi_core_run_ctrl_if.sv
// Host/core handshake bundle for multi_core_run_ctrl.
// runCycles is present only when RUN_CYCLE_COUNT_EN is defined.
interface multi_core_run_ctrl_if #(
    parameter int unsigned CORE_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 16
);

    logic                  start;
    logic [CORE_COUNT-1:0] coreReady;
    logic [CORE_COUNT-1:0] coreDone;
    logic                  processStart;
    logic                  busy;
    logic                  allDone;
    logic                  timeout;

`ifdef RUN_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0]  runCycles;

    modport master (
        output start, coreReady, coreDone,
        input  processStart, busy, allDone, timeout, runCycles
    );

    modport slave (
        input  start, coreReady, coreDone,
        output processStart, busy, allDone, timeout, runCycles
    );
`else
    modport master (
        output start, coreReady, coreDone,
        input  processStart, busy, allDone, timeout
    );

    modport slave (
        input  start, coreReady, coreDone,
        output processStart, busy, allDone, timeout
    );
`endif

endinterface

// File: rtl/multi_core_run_ctrl.sv
// Run sequencer: waits for all cores ready, broadcasts a start pulse, collects done, aborts on timeout.
// Defining RUN_CYCLE_COUNT_EN adds the runCycles result register/port.
module multi_core_run_ctrl
    import multi_core_pkg::*;
#(
    parameter int unsigned CORE_COUNT     = CORE_COUNT_DEFAULT,
    parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rstN,
    multi_core_run_ctrl_if.slave bus
);

    localparam bit                   TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    run_state_t            state;
    logic [CORE_COUNT-1:0] done_mask;
    logic [CNT_WIDTH-1:0]  run_cnt;
    logic                  process_start_q;
    logic                  busy_q;
    logic                  all_done_q;
    logic                  timeout_q;

    logic [CORE_COUNT-1:0] mask_now;
    logic                  run_complete;
    logic                  run_expired;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    // Completion looks at this cycle's coreDone too, so a single RUN cycle is enough.
    assign mask_now     = done_mask | bus.coreDone;
    assign run_complete = &mask_now;
    assign run_expired  = TIMEOUT_EN && (run_cnt == TIMEOUT_LAST);
    assign cnt_inc      = (&run_cnt) ? run_cnt : run_cnt + 1'b1;

`ifdef RUN_CYCLE_COUNT_EN
    logic [CNT_WIDTH-1:0]  run_cycles_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            run_cycles_q <= '0;
        end else if (state == RUN && (run_complete || run_expired)) begin
            run_cycles_q <= cnt_inc;
        end
    end

    assign bus.runCycles = run_cycles_q;
`endif

    // Outputs are registered alongside the state so they reflect the state being entered.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state           <= IDLE;
            done_mask       <= '0;
            run_cnt         <= '0;
            process_start_q <= 1'b0;
            busy_q          <= 1'b0;
            all_done_q      <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            process_start_q <= 1'b0;
            all_done_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= WAIT_READY;
                        busy_q <= 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (&bus.coreReady) begin
                        state           <= START;
                        process_start_q <= 1'b1;
                    end
                end
                START: begin
                    state     <= RUN;
                    done_mask <= '0;
                    run_cnt   <= '0;
                end
                RUN: begin
                    done_mask <= mask_now;
                    run_cnt   <= cnt_inc;
                    if (run_complete) begin
                        state      <= FINISH;
                        all_done_q <= 1'b1;
                    end else if (run_expired) begin
                        state     <= ERROR;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                ERROR: begin
                    if (bus.start) begin
                        state     <= WAIT_READY;
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.processStart = process_start_q;
    assign bus.busy         = busy_q;
    assign bus.allDone      = all_done_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_multi_core_run_ctrl.sv
// Self-checking bench for multi_core_run_ctrl; runCycles checks are compiled in with RUN_CYCLE_COUNT_EN.
// A run planner derives per-cycle expectations from per-core done times and the timeout limit.
module tb_multi_core_run_ctrl;

    localparam int unsigned NC = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 20;
    localparam int unsigned NEVER = 999;

    localparam logic [NC-1:0] ALL = '1;

    // Packed output order: {processStart, busy, allDone, timeout}
    localparam logic [3:0] O_IDLE  = 4'b0000;
    localparam logic [3:0] O_BUSY  = 4'b0100;
    localparam logic [3:0] O_START = 4'b1100;
    localparam logic [3:0] O_FIN   = 4'b0110;
    localparam logic [3:0] O_ERR   = 4'b0001;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    multi_core_run_ctrl_if #(.CORE_COUNT(NC), .CNT_WIDTH(CW)) bus ();

    multi_core_run_ctrl #(
        .CORE_COUNT    (NC),
        .CNT_WIDTH     (CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .bus (bus)
    );

    typedef struct packed {
        logic          start;
        logic [NC-1:0] ready;
        logic [NC-1:0] done;
        logic [3:0]    exp;
        logic [CW-1:0] exp_rc;
    } step_t;

    step_t         plan[$];
    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;
    logic [CW-1:0] last_rc     = '0;

    function automatic logic rnd1();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [NC-1:0] rnd4();
        return NC'($urandom);
    endfunction

    function automatic void add(input logic s, input logic [NC-1:0] r, input logic [NC-1:0] d,
                                input logic [3:0] e);
        step_t st;
        st.start  = s;
        st.ready  = r;
        st.done   = d;
        st.exp    = e;
        st.exp_rc = last_rc;
        plan.push_back(st);
    endfunction

    // A run finishes in RUN cycle max(d) if that is within TO cycles, otherwise aborts after TO cycles.
    function automatic void plan_run(input int unsigned ready_delay, input logic [NC-1:0] partial,
                                     input int unsigned d[NC], input bit level, input bit early,
                                     input int unsigned linger);
        int unsigned   c = 0;
        int unsigned   last;
        bit            fin;
        logic [NC-1:0] dn;
        for (int i = 0; i < NC; i++) if (d[i] > c) c = d[i];
        fin  = (c <= TO);
        last = fin ? c : TO;
        add(1'b1, (ready_delay != 0) ? partial : ALL, early ? ALL : rnd4(), O_BUSY);
        for (int unsigned w = 0; w < ready_delay; w++)
            add(rnd1(), partial, early ? ALL : rnd4(), O_BUSY);
        add(rnd1(), ALL, early ? ALL : rnd4(), O_START);
        add(rnd1(), rnd4(), early ? ALL : rnd4(), O_BUSY);
        for (int unsigned r = 1; r <= last; r++) begin
            for (int i = 0; i < NC; i++)
                dn[i] = (r == d[i]) || (r > d[i] && (level || rnd1()));
            if (r == last) begin
                last_rc = CW'(last);
                add(rnd1(), rnd4(), dn, fin ? O_FIN : O_ERR);
            end else begin
                add(rnd1(), rnd4(), dn, O_BUSY);
            end
        end
        if (fin) begin
            add(rnd1(), rnd4(), rnd4(), O_IDLE);
            add(1'b0, rnd4(), rnd4(), O_IDLE);
        end else begin
            for (int unsigned k = 0; k < linger; k++)
                add(1'b0, rnd4(), rnd4(), O_ERR);
        end
    endfunction

    task automatic exec_plan(input string tag);
        step_t st;
        while (plan.size() > 0) begin
            st = plan.pop_front();
            bus.start     = st.start;
            bus.coreReady = st.ready;
            bus.coreDone  = st.done;
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.processStart, bus.busy, bus.allDone, bus.timeout} !== st.exp) begin
                miscompares++;
                $display("FAIL %s outputs{ps,busy,done,to} got %b expected %b at %0t", tag,
                         {bus.processStart, bus.busy, bus.allDone, bus.timeout}, st.exp, $time);
            end
`ifdef RUN_CYCLE_COUNT_EN
            vectors++;
            if (bus.runCycles !== st.exp_rc) begin
                miscompares++;
                $display("FAIL %s runCycles got %0d expected %0d at %0t", tag, bus.runCycles,
                         st.exp_rc, $time);
            end
`endif
        end
    endtask

    task automatic test_reset();
        bus.start     = 1'b1;
        bus.coreReady = ALL;
        bus.coreDone  = ALL;
        #2;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({bus.processStart, bus.busy, bus.allDone, bus.timeout} !== O_IDLE) begin
                miscompares++;
                $display("FAIL reset outputs got %b expected %b", {bus.processStart, bus.busy,
                         bus.allDone, bus.timeout}, O_IDLE);
            end
`ifdef RUN_CYCLE_COUNT_EN
            vectors++;
            if (bus.runCycles !== '0) begin
                miscompares++;
                $display("FAIL reset runCycles got %0d expected 0", bus.runCycles);
            end
`endif
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        rstN      = 1'b1;
        add(1'b0, ALL, ALL, O_IDLE);
        add(1'b0, rnd4(), rnd4(), O_IDLE);
        exec_plan("post_reset_idle");
    endtask

    task automatic test_spec_run();
        int unsigned d[NC];
        d = '{3, 5, 5, 7};
        plan_run(0, ALL, d, 1'b0, 1'b0, 0);
        exec_plan("spec_run");
    endtask

    task automatic test_ready_wait();
        int unsigned d[NC];
        d = '{2, 3, 1, 4};
        plan_run(10, 4'b1011, d, 1'b1, 1'b0, 0);
        exec_plan("ready_wait");
    endtask

    task automatic test_min_run();
        int unsigned d[NC];
        d = '{1, 1, 1, 1};
        plan_run(0, ALL, d, 1'b0, 1'b0, 0);
        exec_plan("min_run");
    endtask

    task automatic test_timeout();
        int unsigned d[NC];
        d = '{4, 6, NEVER, 2};
        plan_run(0, ALL, d, 1'b1, 1'b0, 3);
        exec_plan("timeout");
        d = '{5, 2, 8, 3};
        plan_run(1, 4'b0111, d, 1'b0, 1'b0, 0);
        exec_plan("restart_after_error");
    endtask

    task automatic test_timeout_boundary();
        int unsigned d[NC];
        d = '{TO, 1, 1, 1};
        plan_run(0, ALL, d, 1'b0, 1'b0, 0);
        exec_plan("done_on_last_cycle");
        d = '{1, TO + 1, 1, 1};
        plan_run(0, ALL, d, 1'b1, 1'b0, 2);
        exec_plan("done_one_too_late");
    endtask

    task automatic test_early_done();
        int unsigned d[NC];
        d = '{2, 4, 3, 5};
        plan_run(2, 4'b1110, d, 1'b0, 1'b1, 0);
        exec_plan("early_done");
    endtask

    task automatic test_reset_midrun();
        logic [3:0] seq[6];
        seq = '{O_BUSY, O_START, O_BUSY, O_BUSY, O_BUSY, O_BUSY};
        bus.start     = 1'b1;
        bus.coreReady = ALL;
        bus.coreDone  = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({bus.processStart, bus.busy, bus.allDone, bus.timeout} !== seq[k]) begin
                miscompares++;
                $display("FAIL midrun_seq[%0d] got %b expected %b", k, {bus.processStart,
                         bus.busy, bus.allDone, bus.timeout}, seq[k]);
            end
        end
        #2;
        rstN = 1'b0;
        #1;
        last_rc = '0;
        vectors++;
        if ({bus.processStart, bus.busy, bus.allDone, bus.timeout} !== O_IDLE) begin
            miscompares++;
            $display("FAIL async_reset outputs got %b expected %b", {bus.processStart, bus.busy,
                     bus.allDone, bus.timeout}, O_IDLE);
        end
`ifdef RUN_CYCLE_COUNT_EN
        vectors++;
        if (bus.runCycles !== '0) begin
            miscompares++;
            $display("FAIL async_reset runCycles got %0d expected 0", bus.runCycles);
        end
`endif
        @(posedge clk);
        #1;
        rstN      = 1'b1;
        bus.start = 1'b0;
        add(1'b0, ALL, ALL, O_IDLE);
        add(1'b0, ALL, rnd4(), O_IDLE);
        exec_plan("idle_after_reset");
    endtask

    task automatic test_random();
        int unsigned   d[NC];
        logic [NC-1:0] partial;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NC; i++) d[i] = $urandom_range(1, 14);
            if ($urandom_range(0, 4) == 0) d[$urandom_range(0, NC - 1)] = $urandom_range(TO - 1, TO + 6);
            do partial = rnd4(); while (partial == ALL);
            plan_run($urandom_range(0, 3), partial, d, rnd1(), rnd1(), $urandom_range(1, 3));
            exec_plan("random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_run();
        test_ready_wait();
        test_min_run();
        test_timeout();
        test_timeout_boundary();
        test_early_done();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
